// File: rtl/fp_norm_64.sv
// fp_norm_64: two-stage valid/ready normalizer for 64-bit unsigned mantissas.
// Stage 1 captures the operand and feeds a leading-one detector; stage 2
// shifts the mantissa so its top one lands on bit 63 and lowers the exponent
// by the same amount. lzc_64 is the companion leading-one detector.

module lzc_64 (
  input  logic [63:0] a,
  output logic        v,
  output logic [5:0]  c
);

  // Any-one flag plus index of the most significant set bit (0 when a == 0).
  always_comb begin
    v = |a;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) c = 6'(i);
    end
  end

endmodule

module fp_norm_64 #(
  parameter int EXP_W = 14,
  parameter int TAG_W = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_mant,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_mant,
  output logic signed [EXP_W-1:0] out_exp,
  output logic                    out_zero,
  output logic [TAG_W-1:0]        out_tag
);

  // Exponent minus shift; wraps modulo 2^EXP_W, range checks happen downstream.
  function automatic logic signed [EXP_W-1:0] exp_adjust(
    input logic signed [EXP_W-1:0] e,
    input logic [5:0]              sh
  );
    logic signed [EXP_W-1:0] sh_ext;
    sh_ext = EXP_W'(sh);
    return e - sh_ext;
  endfunction

  // Stage 1 registers
  logic                    s1_v_q, s1_v_d;
  logic [63:0]             s1_mant_q, s1_mant_d;
  logic signed [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;

  // Stage 2 registers (drive the outputs directly)
  logic                    s2_v_q, s2_v_d;
  logic [63:0]             s2_mant_q, s2_mant_d;
  logic signed [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic                    s2_zero_q, s2_zero_d;
  logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;

  logic       s1_adv, s2_adv, s1_acc, s2_load;
  logic       lz_v;
  logic [5:0] lz_c;
  logic [5:0] sh;

  lzc_64 u_lzc (
    .a (s1_mant_q),
    .v (lz_v),
    .c (lz_c)
  );

  // A stage may advance when it is empty or the stage after it is advancing.
  assign s2_adv   = ~s2_v_q | out_ready;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign in_ready = s1_adv & ~flush;
  assign s1_acc   = in_valid & in_ready;
  assign s2_load  = s2_adv & s1_v_q & ~flush;
  assign sh       = ~lz_c;

  // Valid bits: flush kills both stages, otherwise advance per stall logic.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (s1_adv) s1_v_d = s1_acc;
      if (s2_adv) s2_v_d = s1_v_q;
    end
  end

  // Stage 1 data: capture operand only on an accepted transfer, else hold.
  always_comb begin
    s1_mant_d = s1_mant_q;
    s1_exp_d  = s1_exp_q;
    s1_tag_d  = s1_tag_q;
    if (s1_acc) begin
      s1_mant_d = in_mant;
      s1_exp_d  = in_exp;
      s1_tag_d  = in_tag;
    end
  end

  // Stage 2 data: normalize the stage-1 operand; zero mantissa gives a clean zero.
  always_comb begin
    s2_mant_d = s2_mant_q;
    s2_exp_d  = s2_exp_q;
    s2_zero_d = s2_zero_q;
    s2_tag_d  = s2_tag_q;
    if (s2_load) begin
      s2_tag_d = s1_tag_q;
      if (lz_v) begin
        s2_mant_d = s1_mant_q << sh;
        s2_exp_d  = exp_adjust(s1_exp_q, sh);
        s2_zero_d = 1'b0;
      end else begin
        s2_mant_d = '0;
        s2_exp_d  = '0;
        s2_zero_d = 1'b1;
      end
    end
  end

  // Pipeline state; asynchronous reset empties the pipe and clears all data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_mant_q <= '0;
      s2_exp_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mant_q <= s1_mant_d;
      s1_exp_q  <= s1_exp_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_mant_q <= s2_mant_d;
      s2_exp_q  <= s2_exp_d;
      s2_zero_q <= s2_zero_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_mant  = s2_mant_q;
  assign out_exp   = s2_exp_q;
  assign out_zero  = s2_zero_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fp_norm_64.sv
// Scoreboard bench for fp_norm_64: a reference normalizer predicts each
// accepted operand, results are popped and compared as they leave the DUT.

module tb_fp_norm_64;
  localparam int EXP_W = 14;
  localparam int TAG_W = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [63:0]             in_mant = '0;
  logic signed [EXP_W-1:0] in_exp = '0;
  logic [TAG_W-1:0]        in_tag = '0;
  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             out_mant;
  logic signed [EXP_W-1:0] out_exp;
  logic                    out_zero;
  logic [TAG_W-1:0]        out_tag;

  fp_norm_64 #(.EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]             m;
    logic signed [EXP_W-1:0] e;
    logic                    z;
    logic [TAG_W-1:0]        t;
    int                      c;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
  bit   lat_chk = 1'b0;

  bit          hold_pend = 1'b0;
  logic [63:0] hold_m;
  logic [63:0] hold_meta;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference: shift left one bit at a time until bit 63 is set.
  function automatic exp_t model(input logic [63:0] m, input logic signed [EXP_W-1:0] e,
                                 input logic [TAG_W-1:0] t, input int c);
    exp_t r;
    int   sh;
    r.t = t;
    r.c = c;
    if (m == 64'd0) begin
      r.m = '0;
      r.e = '0;
      r.z = 1'b1;
    end else begin
      sh = 0;
      while (!m[63]) begin
        m = m << 1;
        sh++;
      end
      r.m = m;
      r.e = e - EXP_W'(sh);
      r.z = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (rdy_mode == 1);
  end

  // Monitor: hold check, in_ready prediction, output pop/compare, input push.
  always @(negedge clock) begin
    exp_t e;
    if (hold_pend && reset) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_mant", out_mant, hold_m);
      chk("hold_meta", 64'({out_exp, out_zero, out_tag}), hold_meta);
    end
    hold_pend = reset && !flush && out_valid && !out_ready;
    hold_m    = out_mant;
    hold_meta = 64'({out_exp, out_zero, out_tag});

    chk("in_ready", 64'(in_ready), 64'(!flush && (sb.size() < 2 || out_ready)));

    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_mant", out_mant, e.m);
          chk("out_exp", 64'(out_exp), 64'(e.e));
          chk("out_zero", 64'(out_zero), 64'(e.z));
          chk("out_tag", 64'(out_tag), 64'(e.t));
          if (lat_chk) chk("latency", 64'(cyc - e.c), 64'd2);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp, in_tag, cyc));
    end
  end

  task automatic send(input logic [63:0] m, input logic signed [EXP_W-1:0] e,
                      input logic [TAG_W-1:0] t);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    in_tag   = t;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd_mant();
    logic [63:0] m;
    m = {$urandom, $urandom};
    return m >> $urandom_range(0, 63);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs toggling
    repeat (4) begin
      @(posedge clock);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_mant  = {$urandom, $urandom};
      in_exp   = EXP_W'($urandom);
      in_tag   = TAG_W'($urandom);
      @(negedge clock);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_mant", out_mant, 64'd0);
      chk("rst_meta", 64'({out_exp, out_zero, out_tag}), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    lat_chk  = 1'b1;

    // Directed normalization cases
    send(64'h0000_0000_0000_0001, 14'sd10, 4'h1);
    send(64'h8000_0000_0000_0000, 14'sd5, 4'h2);
    send(64'h0000_0001_8000_0000, 14'sd0, 4'h3);
    send(64'h0, 14'sd100, 4'hA);
    send(64'h0000_0000_0000_0003, -14'sd8190, 4'h4);
    drain();

    // Full-rate stream
    for (int i = 0; i < 16; i++) send(rnd_mant(), EXP_W'($urandom), TAG_W'(i));
    drain();

    // Back-pressure with random out_ready
    lat_chk  = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send(rnd_mant(), EXP_W'($urandom), TAG_W'(i));
    rdy_mode = 1;
    drain();

    // Fill both stages, then flush
    rdy_mode = 0;
    @(posedge clock);
    #1;
    send(rnd_mant(), 14'sd7, 4'h5);
    send(rnd_mant(), 14'sd9, 4'h6);
    @(negedge clock);
    chk("full_block", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    rdy_mode = 1;
    lat_chk  = 1'b1;
    @(posedge clock);
    #1;
    send(64'h0000_0000_00F0_0000, 14'sd40, 4'h7);
    drain();

    // Reset while operands are in flight
    send(rnd_mant(), 14'sd1, 4'h8);
    send(rnd_mant(), 14'sd2, 4'h9);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_mant", out_mant, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(64'h0000_0000_0000_0400, 14'sd0, 4'hB);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_norm_64.md
# fp_norm_64

Two-stage pipelined normalizer for 64-bit unsigned mantissas with a valid/ready handshake. Each accepted operand is left-shifted until its most significant one reaches bit 63, and its signed exponent is reduced by the shift amount. The block sits directly downstream of the 64-bit leading-one detector `lzc_64`: it instantiates one `lzc_64` in stage 1 and consumes the detector's result in stage 2. It feeds the rounding stage of the FPU datapath.

## Interface
- `EXP_W`, 14: exponent width, two's-complement signed.
- `TAG_W`, 4: width of the opaque tag carried alongside each operand.
- `reset`  in  1  asynchronous, active-low reset.
- `clock`  in  1  rising-edge clock.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  block accepts the operand this cycle.
- `in_mant`  in  64  unnormalized mantissa.
- `in_exp`  in  EXP_W  signed exponent.
- `in_tag`  in  TAG_W  tag, passed through unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_mant`  out  64  normalized mantissa.
- `out_exp`  out  EXP_W  adjusted exponent.
- `out_zero`  out  1  input mantissa was zero.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Transfer rules: an input transfers when `in_valid & in_ready`. An output transfers when `out_valid & out_ready`.
- Stage 1 (S1) registers `in_mant`, `in_exp` and `in_tag`, and sets `s1_v`.
- The `lzc_64` instance is driven by the S1 mantissa register. It returns `v`, which is 1 if any bit is set, and `c`, the bit index of the most significant one.
- Stage 2 (S2) registers the stage-1 results:
  - Shift amount: `sh = ~c`, which equals 63 − c (6 bits, range 0..63).
  - Non-zero input (`v = 1`):
    - `out_mant = mant << sh`, so bit 63 of the result is always 1.
    - `out_exp = exp − sh`. The subtraction is computed at EXP_W bits and wraps modulo 2^EXP_W. There is no saturation; range checking belongs to the rounding stage.
    - `out_zero = 0`.
  - Zero input (`v = 0`): `out_mant = 0`, `out_exp = 0`, `out_zero = 1`. The detector's `c` is ignored.
  - `out_tag` is the S1 tag, unchanged.
- Stall logic:
  - `s2_adv = ~s2_v | out_ready`
  - `s1_adv = ~s1_v | s2_adv`
  - `in_ready = s1_adv & ~flush` (combinational).
- S1 → S2 move: when `s1_adv` is high, S1 loads (`s1_v <= in_valid & in_ready`). When `s2_adv` is high, S2 loads from S1 (`s2_v <= s1_v`).
- Hold rule: a stalled stage holds all of its registers unchanged.
- Flush:
  - When `flush = 1` at a clock edge, `s1_v` and `s2_v` clear to 0.
  - No input is accepted in that cycle, because `in_ready = 0`.
  - The data registers are left unchanged.
- No internal FSM beyond the two valid bits. Pipeline states are empty, S1 only, S2 only, and full.

## Timing
- Reset (asynchronous, while `reset = 0`):
  - `s1_v = s2_v = 0`.
  - All data registers are 0, so `out_mant = 0`, `out_exp = 0`, `out_zero = 0`, `out_tag = 0` and `out_valid = 0`.
  - `in_ready = 1` whenever `flush = 0`.
- Reset asserted mid-operation discards all in-flight operands immediately.
- Latency: an operand accepted at edge N appears with `out_valid = 1` after edge N+1. Assuming no stall, it is consumed at edge N+2 when `out_ready = 1`.
- Throughput: one operand per cycle while `out_ready = 1`.
- Full pipeline with `out_ready = 0`: `in_ready = 0`. Both stages hold.
- Simultaneous accept and emit: when full and `out_ready = 1`, S2 emits, S1 moves to S2 and a new input enters S1, all at the same edge.
- `out_*` are driven directly from registers. `in_ready` is the only combinational output.
- Outputs are stable while `out_valid & ~out_ready`.

## Test plan
- **Reset:** hold `reset = 0` with random inputs → `out_valid = 0`, all outputs 0, `in_ready = 1`. Release reset → first accepted operand emerges 2 cycles later.
- **Normalization, with `out_ready = 1`:**
  - `in_mant = 64'h0000_0000_0000_0001`, `in_exp = 10` → `out_mant = 64'h8000_0000_0000_0000`, `out_exp = −53`, `out_zero = 0`.
  - `in_mant = 64'h8000_0000_0000_0000`, `in_exp = 5` → output unchanged, `out_exp = 5`.
  - `in_mant = 64'h0000_0001_8000_0000`, `in_exp = 0` → `out_mant = 64'hC000_0000_0000_0000`, `out_exp = −31`.
- **Zero input:** `in_mant = 0`, `in_exp = 100`, `in_tag = 4'hA` → `out_zero = 1`, `out_mant = 0`, `out_exp = 0`, `out_tag = 4'hA`.
- **Back-pressure:** stream tags 0..7 with `out_ready` toggling randomly → `in_ready` deasserts once both stages are full. Outputs hold while stalled; all 8 results arrive in order with correct values, and none is lost or duplicated.
- **Full-rate stream:** 16 back-to-back operands with `out_ready = 1` → one result per cycle, first result 2 cycles after the first accept.
- **Flush:** with both stages full, assert `flush` for 1 cycle → `out_valid = 0` on the next cycle and `in_ready = 0` during the flush cycle. The next operand sent afterwards emerges normally after 2 cycles.
